// File: rtl/cpu_pkg.sv
// Constants and pipeline payload types shared by the fetch stage, the decoder and later stages.
package cpu_pkg;

  localparam int unsigned ISN_W = 32;
  localparam int unsigned PC_W  = 32;

  localparam logic [ISN_W-1:0] NOP_ISN          = 32'h0000_0000;
  localparam logic [PC_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;

  // One pipeline latch entry: instruction word plus the word address it came from.
  typedef struct packed {
    logic             valid;
    logic [ISN_W-1:0] isn;
    logic [PC_W-1:0]  pc;
  } fd_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Synchronous instruction ROM port: the fetch stage is the master, the ROM the slave.
interface fetch_unit_if #(
  parameter int unsigned IMEM_AW = 12
) ();

  logic                       en;
  logic [IMEM_AW-1:0]         addr;
  logic [cpu_pkg::ISN_W-1:0]  rdata;

  modport master (output en, output addr, input rdata);
  modport slave  (input en, input addr, output rdata);

endinterface

// File: rtl/fd_pipe_reg.sv
// Generic pipeline latch with hold, squash-to-NOP and async active-low reset.
module fd_pipe_reg
  import cpu_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  logic      hold_i,
  input  logic      squash_i,
  input  fd_entry_t d_i,
  output fd_entry_t q_o
);

  fd_entry_t entry_q;

  // Squash beats hold so a redirect is never lost behind a stall; the pc field is left as is.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      entry_q.valid <= 1'b0;
      entry_q.isn   <= NOP_ISN;
      entry_q.pc    <= '0;
    end else if (squash_i) begin
      entry_q.valid <= 1'b0;
      entry_q.isn   <= NOP_ISN;
    end else if (!hold_i) begin
      entry_q <= d_i;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous ROM and feeds the F/D latch.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     IMEM_AW  = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  fetch_unit_if.master      imem,
  output logic              fd_valid,
  output logic [ISN_W-1:0]  fd_isn,
  output logic [PC_W-1:0]   fd_pc,
  output logic [PC_W-1:0]   fd_pc_next,
  output logic [PC_W-1:0]   fetch_count
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] f_pc_q, f_pc_d;
  logic            f_valid_q, f_valid_d;
  logic [PC_W-1:0] count_q, count_d;
  fd_entry_t       fd_d, fd_q;

  // Stalling disables the ROM so its output register keeps matching f_pc_q.
  assign imem.en   = ~stall;
  assign imem.addr = pc_q[IMEM_AW-1:0];

  always_comb begin
    pc_d      = pc_q;
    f_pc_d    = f_pc_q;
    f_valid_d = f_valid_q;
    count_d   = count_q;
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      f_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d      = pc_q + PC_W'(1);
      f_pc_d    = pc_q;
      f_valid_d = 1'b1;
      if (f_valid_q) begin
        count_d = count_q + PC_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC;
      f_pc_q    <= RESET_PC;
      f_valid_q <= 1'b0;
      count_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      f_pc_q    <= f_pc_d;
      f_valid_q <= f_valid_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    fd_d.valid = f_valid_q;
    fd_d.isn   = f_valid_q ? imem.rdata : NOP_ISN;
    fd_d.pc    = f_pc_q;
  end

  fd_pipe_reg u_fd_reg (
    .clock    (clock),
    .reset_n  (reset_n),
    .hold_i   (stall),
    .squash_i (redirect_valid),
    .d_i      (fd_d),
    .q_o      (fd_q)
  );

  assign fd_valid    = fd_q.valid;
  assign fd_isn      = fd_q.isn;
  assign fd_pc       = fd_q.pc;
  assign fd_pc_next  = fd_q.pc + PC_W'(1);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, wrap instance, mid-stream reset, random run.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0010;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, rdv;
  logic [31:0] rdpc;
  logic        fd_valid, w_fd_valid;
  logic [31:0] fd_isn, fd_pc, fd_pc_next, fetch_count;
  logic [31:0] w_fd_isn, w_fd_pc, w_fd_pc_next, w_fetch_count;

  fetch_unit_if #(.IMEM_AW(12)) imem_m ();
  fetch_unit_if #(.IMEM_AW(4))  imem_w ();

  fetch_unit #(.RESET_PC(RST_PC), .IMEM_AW(12)) dut (
    .clock(clk), .reset_n(rst_n), .stall(stall), .redirect_valid(rdv), .redirect_pc(rdpc),
    .imem(imem_m), .fd_valid(fd_valid), .fd_isn(fd_isn), .fd_pc(fd_pc),
    .fd_pc_next(fd_pc_next), .fetch_count(fetch_count));

  fetch_unit #(.RESET_PC(32'h0000_000E), .IMEM_AW(4)) dut_wrap (
    .clock(clk), .reset_n(rst_n), .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem(imem_w), .fd_valid(w_fd_valid), .fd_isn(w_fd_isn), .fd_pc(w_fd_pc),
    .fd_pc_next(w_fd_pc_next), .fetch_count(w_fetch_count));

  // ROM contents: nonzero, address-dependent words.
  function automatic logic [31:0] rom_word(input logic [11:0] a);
    return 32'h8000_0000 | ({20'h0, a} * 32'h0001_0003);
  endfunction

  always @(posedge clk) begin
    if (imem_m.en) imem_m.rdata <= rom_word(imem_m.addr);
    if (imem_w.en) imem_w.rdata <= rom_word({8'h0, imem_w.addr});
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of in-flight fetches, one slot deep between PC and F/D.
  typedef struct { logic v; logic [31:0] pc; } slot_t;
  slot_t       f_q[$];
  logic [31:0] m_next, m_fpc, m_isn, m_cnt;
  logic        m_fv;

  task automatic model_reset();
    f_q.delete();
    f_q.push_back('{v: 1'b0, pc: RST_PC});
    m_next = RST_PC; m_fv = 1'b0; m_fpc = 32'h0; m_isn = 32'h0; m_cnt = 32'h0;
  endtask

  task automatic model_edge(input logic st, input logic rd, input logic [31:0] rp);
    slot_t s;
    if (rd) begin
      f_q.delete();
      f_q.push_back('{v: 1'b0, pc: 32'h0});
      m_fv = 1'b0; m_isn = 32'h0; m_next = rp;
    end else if (!st) begin
      s = f_q.pop_front();
      m_fv  = s.v;
      m_isn = s.v ? rom_word(s.pc[11:0]) : 32'h0;
      if (s.v) begin
        m_fpc = s.pc;
        m_cnt = m_cnt + 32'd1;
      end
      f_q.push_back('{v: 1'b1, pc: m_next});
      m_next = m_next + 32'd1;
    end
  endtask

  typedef struct {
    logic        s;
    logic        r;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ecnt;
  } vec_t;

  vec_t        vecs[21];
  logic [31:0] wrap_addr[4];
  logic [31:0] exp_isn, wpc;

  initial begin
    // inputs sampled at edge i+1, then F/D expectations after that edge
    vecs[0]  = '{0, 0, 32'h00, 0, 32'h00, 0};
    vecs[1]  = '{0, 0, 32'h00, 1, 32'h10, 1};
    vecs[2]  = '{0, 0, 32'h00, 1, 32'h11, 2};
    vecs[3]  = '{1, 0, 32'h00, 1, 32'h11, 2};
    vecs[4]  = '{1, 0, 32'h00, 1, 32'h11, 2};
    vecs[5]  = '{1, 0, 32'h00, 1, 32'h11, 2};
    vecs[6]  = '{0, 0, 32'h00, 1, 32'h12, 3};
    vecs[7]  = '{0, 1, 32'h40, 0, 32'h00, 3};
    vecs[8]  = '{0, 0, 32'h00, 0, 32'h00, 3};
    vecs[9]  = '{0, 0, 32'h00, 1, 32'h40, 4};
    vecs[10] = '{0, 0, 32'h00, 1, 32'h41, 5};
    vecs[11] = '{1, 1, 32'h80, 0, 32'h00, 5};
    vecs[12] = '{1, 0, 32'h00, 0, 32'h00, 5};
    vecs[13] = '{1, 0, 32'h00, 0, 32'h00, 5};
    vecs[14] = '{0, 0, 32'h00, 0, 32'h00, 5};
    vecs[15] = '{0, 0, 32'h00, 1, 32'h80, 6};
    vecs[16] = '{0, 1, 32'h20, 0, 32'h00, 6};
    vecs[17] = '{0, 1, 32'h30, 0, 32'h00, 6};
    vecs[18] = '{0, 0, 32'h00, 0, 32'h00, 6};
    vecs[19] = '{0, 0, 32'h00, 1, 32'h30, 7};
    vecs[20] = '{0, 0, 32'h00, 1, 32'h31, 8};
    wrap_addr[0] = 32'hE; wrap_addr[1] = 32'hF; wrap_addr[2] = 32'h0; wrap_addr[3] = 32'h1;

    rst_n = 1'b0; stall = 1'b0; rdv = 1'b0; rdpc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fd_valid", {31'h0, fd_valid}, 32'h0);
    chk("rst_fd_isn", fd_isn, 32'h0);
    chk("rst_fd_pc", fd_pc, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_imem_addr", {20'h0, imem_m.addr}, RST_PC);
    stall = 1'b1; #1;
    chk("rst_imem_en_stall", {31'h0, imem_m.en}, 32'h0);
    stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      stall = vecs[i].s; rdv = vecs[i].r; rdpc = vecs[i].rpc;
      #1;
      chk("vec_imem_en", {31'h0, imem_m.en}, {31'h0, ~vecs[i].s});
      if (i < 4) chk("wrap_imem_addr", {28'h0, imem_w.addr}, wrap_addr[i]);
      @(posedge clk); #1;
      exp_isn = vecs[i].ev ? rom_word(vecs[i].epc[11:0]) : 32'h0;
      chk("vec_fd_valid", {31'h0, fd_valid}, {31'h0, vecs[i].ev});
      chk("vec_fd_isn", fd_isn, exp_isn);
      chk("vec_count", fetch_count, vecs[i].ecnt);
      if (vecs[i].ev) begin
        chk("vec_fd_pc", fd_pc, vecs[i].epc);
        chk("vec_fd_pc_next", fd_pc_next, vecs[i].epc + 32'd1);
      end
      if (i >= 1 && i <= 4) begin
        wpc = 32'hE + 32'(i - 1);
        chk("wrap_fd_valid", {31'h0, w_fd_valid}, 32'h1);
        chk("wrap_fd_pc", w_fd_pc, wpc);
        chk("wrap_fd_isn", w_fd_isn, rom_word({8'h0, wpc[3:0]}));
      end
      if (i == 4) begin
        chk("wrap_count", w_fetch_count, 32'd4);
        chk("wrap_pc_next", w_fd_pc_next, 32'h12);
      end
    end

    // Mid-stream reset pulse between edges
    stall = 1'b0; rdv = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_fd_valid", {31'h0, fd_valid}, 32'h0);
    chk("midrst_fd_isn", fd_isn, 32'h0);
    chk("midrst_count", fetch_count, 32'h0);
    chk("midrst_imem_addr", {20'h0, imem_m.addr}, RST_PC);
    rst_n = 1'b1;
    model_reset();

    for (int c = 0; c < 400; c++) begin
      if (c < 3) begin
        stall = 1'b0; rdv = 1'b0; rdpc = 32'h0;
      end else begin
        stall = ($urandom_range(0, 99) < 25);
        rdv   = ($urandom_range(0, 99) < 10);
        rdpc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
      end
      #1;
      chk("rnd_imem_en", {31'h0, imem_m.en}, {31'h0, ~stall});
      chk("rnd_imem_addr", {20'h0, imem_m.addr}, {20'h0, m_next[11:0]});
      @(posedge clk);
      model_edge(stall, rdv, rdpc);
      #1;
      chk("rnd_fd_valid", {31'h0, fd_valid}, {31'h0, m_fv});
      chk("rnd_fd_isn", fd_isn, m_isn);
      chk("rnd_count", fetch_count, m_cnt);
      if (m_fv) begin
        chk("rnd_fd_pc", fd_pc, m_fpc);
        chk("rnd_fd_pc_next", fd_pc_next, m_fpc + 32'd1);
      end
      if (c == 1) chk("restart_fd_pc", fd_pc, RST_PC);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction decoder. It owns the program counter and drives a synchronous instruction ROM. It holds the fetch/decode (F/D) pipeline register whose `fd_isn` output feeds the decoder's 32-bit instruction input. It supports pipeline stalls and a single redirect port for taken branches and jumps, and squashes wrong-path instructions to NOP.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, word address fetched first after reset.
- `IMEM_AW`, 12, instruction ROM address width in words.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  downstream cannot accept a new F/D entry this cycle.
- `redirect_valid`  in  1  taken branch or jump resolved downstream.
- `redirect_pc`  in  32  word address of the redirect target.
- `imem_en`  out  1  ROM read enable. The ROM output register holds its value when this is low.
- `imem_addr`  out  IMEM_AW  ROM word address.
- `imem_rdata`  in  32  ROM data, valid one cycle after the address is presented with `imem_en`=1.
- `fd_valid`  out  1  F/D entry holds a real instruction.
- `fd_isn`  out  32  instruction to the decoder; NOP when `fd_valid`=0.
- `fd_pc`  out  32  word address of `fd_isn`.
- `fd_pc_next`  out  32  `fd_pc`+1, mod 2^32.
- `fetch_count`  out  32  number of instructions loaded into F/D since reset.

## Operation
- State:
  - `pc_q` is the address presented to the ROM this cycle.
  - `f_pc_q` and `f_valid_q` describe the data currently on `imem_rdata`.
  - The F/D register holds `fd_valid`, `fd_isn` and `fd_pc`.
  - `fetch_count` is a 32-bit counter.
- Combinational outputs: `imem_addr` = `pc_q[IMEM_AW-1:0]`; `imem_en` = `~stall`.
- Per-edge priority is reset > redirect > stall > advance.
  - **Redirect:** `pc_q`←`redirect_pc`; `f_valid_q`←0; `fd_valid`←0; `fd_isn`←NOP. Redirect wins over a simultaneous stall. Both in-flight instructions are wrong-path and are squashed, for a penalty of 2 bubbles.
  - **Stall** (no redirect): every register holds. The ROM output holds because `imem_en`=0, so `imem_rdata` still matches `f_pc_q`.
  - **Advance:**
    - `pc_q`←`pc_q`+1.
    - `f_pc_q`←`pc_q`; `f_valid_q`←1.
    - `fd_valid`←`f_valid_q`; `fd_isn`←`f_valid_q` ? `imem_rdata` : NOP; `fd_pc`←`f_pc_q`.
    - `fetch_count`←`fetch_count`+1 when `f_valid_q`=1.
- Arithmetic: the PC is a 32-bit word address that wraps mod 2^32. The ROM address silently wraps at 2^IMEM_AW. `fetch_count` wraps mod 2^32.
- NOP encoding is 32'h0000_0000 (opcode 0).

## Timing
- Reset values while `reset_n`=0, applied asynchronously:
  - `pc_q`=`RESET_PC`, `f_pc_q`=`RESET_PC`, `f_valid_q`=0.
  - `fd_valid`=0, `fd_isn`=NOP, `fd_pc`=0, `fetch_count`=0.
  - `imem_en` follows `~stall` (it is combinational).
- After release, the first rising edge latches ROM data for `RESET_PC` into the F stage. The second rising edge loads F/D, so `fd_valid`=1 and `fd_pc`=`RESET_PC`.
- Steady state: one instruction per cycle. `fd_pc` increments by 1 each edge while `stall`=0.
- Redirect latency: `redirect_valid` is sampled at edge N. At edge N+2, `fd_pc`=`redirect_pc` with `fd_valid`=1. Edges N and N+1 leave `fd_valid`=0.
- A redirect followed immediately by a stall holds the bubble; ordering is preserved once the stall releases.
- Back-to-back redirects: the last one sampled wins, and no instruction from the earlier target reaches F/D.
- Asserting `reset_n` mid-stream discards all state immediately. No partial F/D entry survives.

## Structure
- Shared package `cpu_pkg` holds `ISN_W`=32, `PC_W`=32, `NOP_ISN`=32'h0 and the default `RESET_PC`. The decoder and later stages use the same constants.
- One natural sub-module is `fd_pipe_reg`: the F/D register with hold, squash-to-NOP and async active-low reset. It is reused for later pipeline latches.
- Everything else, the PC register, F-stage tracking and the counter, is in `fetch_unit` itself.

## Test plan
- **Reset release:** `RESET_PC`=0x10, ROM[0x10..0x13]=A,B,C,D, no stall. Expect `fd_isn`=A at the 2nd edge, then B, C, D on consecutive edges with `fd_pc` 0x10..0x13 and `fetch_count` 1..4.
- **Stall:** stall for 3 cycles while `fd_isn`=B. Expect `fd_isn`=B, `fd_pc`=0x11 and `fetch_count` to hold, and `imem_en`=0. After release, C then D follow with no duplicate and no skip.
- **Redirect:** `redirect_pc`=0x40 when `fd_pc`=0x12. Expect 2 cycles of `fd_valid`=0 with `fd_isn`=0, then `fd_pc`=0x40 carrying ROM[0x40].
- **Redirect + stall in the same cycle:** same as the redirect case. The redirect is taken, and the bubble holds for as long as the stall persists.
- **Wrap:** `IMEM_AW`=4, start at PC 0xE. Expect `imem_addr` sequence E, F, 0, 1 while `fd_pc` reads 0xE, 0xF, 0x10, 0x11.
- **Mid-stream reset:** pulse `reset_n` low for 1 ns between edges. Expect `fd_valid`=0 and `fetch_count`=0 immediately, and a restart from `RESET_PC`.
